// File: rtl/note_seq.sv
`default_nettype none
// ============================================================================
// Module   : note_seq
// Brief    : Step sequencer for a monophonic synth. It plays a pattern of
//            oscillator periods and drives the trig and gate inputs of the ADSR.
// Revision : 1.0  initial release
// ============================================================================
module note_seq #(
    parameter  int STEPS = 8,
    parameter  int TW    = 16,
    localparam int SW    = $clog2(STEPS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          run,
    input  logic          mute,
    input  logic [TW-1:0] tempo_div,
    input  logic [TW-1:0] gate_len,
    input  logic [SW-1:0] last_step,
    input  logic          wr_en,
    input  logic [SW-1:0] wr_addr,
    input  logic [12:0]   wr_data,
    output logic [11:0]   osc_count,
    output logic          trig,
    output logic          gate,
    output logic [SW-1:0] step,
    output logic          playing
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    localparam logic [12:0]   c_rest_slot = 13'h1000;
    localparam logic [TW-1:0] c_tick_one  = TW'(1);
    localparam logic [SW-1:0] c_step_one  = SW'(1);

    state_t        r_state, w_state_nxt;
    logic [TW-1:0] r_tick, w_tick_nxt;
    logic [SW-1:0] r_step, w_step_nxt, w_step_adv, w_start_idx;
    logic [11:0]   r_osc, w_osc_nxt;
    logic          r_trig, w_trig_nxt;
    logic          r_gate, w_gate_nxt;
    logic          r_rest, w_rest_nxt;
    logic          r_playing;
    logic          w_start;
    logic [12:0]   w_start_slot;
    logic [12:0]   r_slots [STEPS];

    always_comb begin
        w_state_nxt = r_state;
        w_tick_nxt  = r_tick;
        w_step_nxt  = r_step;
        w_trig_nxt  = 1'b0;
        w_gate_nxt  = 1'b0;
        w_start     = 1'b0;
        w_start_idx = '0;
        w_step_adv  = (r_step >= last_step) ? '0 : r_step + c_step_one;

        case (r_state)
            S_IDLE: begin
                if (run && !mute) begin
                    w_state_nxt = S_PLAY;
                    w_tick_nxt  = '0;
                    w_step_nxt  = '0;
                    w_start     = 1'b1;
                end
            end
            S_PLAY, S_HOLD: begin
                if (!run) begin
                    w_state_nxt = S_IDLE;
                    w_tick_nxt  = '0;
                    w_step_nxt  = '0;
                end else if (mute) begin
                    w_state_nxt = S_HOLD;
                end else begin
                    // Leaving HOLD counts as an ordinary tick, so a muted
                    // step still lasts exactly tempo_div+1 playing cycles.
                    w_state_nxt = S_PLAY;
                    if (r_tick == tempo_div) begin
                        w_tick_nxt  = '0;
                        w_step_nxt  = w_step_adv;
                        w_start     = 1'b1;
                        w_start_idx = w_step_adv;
                    end else begin
                        w_tick_nxt = r_tick + c_tick_one;
                        w_gate_nxt = !r_rest && (w_tick_nxt < gate_len);
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_tick_nxt  = '0;
                w_step_nxt  = '0;
            end
        endcase

        // Slot is read from the current array, so a same-edge write is not seen.
        w_start_slot = r_slots[w_start_idx];
        w_rest_nxt   = r_rest;
        w_osc_nxt    = r_osc;
        if (w_start) begin
            w_rest_nxt = w_start_slot[12];
            if (!w_start_slot[12]) begin
                w_osc_nxt = w_start_slot[11:0];
            end
            w_trig_nxt = !w_start_slot[12] && (gate_len != '0);
            w_gate_nxt = w_trig_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_tick    <= '0;
            r_step    <= '0;
            r_osc     <= '0;
            r_trig    <= 1'b0;
            r_gate    <= 1'b0;
            r_rest    <= 1'b1;
            r_playing <= 1'b0;
            for (int i = 0; i < STEPS; i++) begin
                r_slots[i] <= c_rest_slot;
            end
        end else begin
            r_state   <= w_state_nxt;
            r_tick    <= w_tick_nxt;
            r_step    <= w_step_nxt;
            r_osc     <= w_osc_nxt;
            r_trig    <= w_trig_nxt;
            r_gate    <= w_gate_nxt;
            r_rest    <= w_rest_nxt;
            r_playing <= (w_state_nxt != S_IDLE);
            if (wr_en) begin
                r_slots[wr_addr] <= wr_data;
            end
        end
    end

    assign osc_count = r_osc;
    assign trig      = r_trig;
    assign gate      = r_gate;
    assign step      = r_step;
    assign playing   = r_playing;

endmodule
`default_nettype wire

// File: tb/tb_note_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_note_seq
// Brief    : Self-checking bench for note_seq with a cycle-level reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_note_seq;

    logic        clk = 1'b0;
    logic        rst_n, run, mute, wr_en;
    logic [15:0] tempo_div, gate_len;
    logic [2:0]  last_step, wr_addr;
    logic [12:0] wr_data;
    logic [11:0] osc_count;
    logic        trig, gate, playing;
    logic [2:0]  step;

    int total = 0;
    int bad   = 0;
    logic chk_en = 1'b0;
    int exp_osc [4] = '{100, 200, 300, 400};

    note_seq #(.STEPS(8), .TW(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
        .mute      (mute),
        .tempo_div (tempo_div),
        .gate_len  (gate_len),
        .last_step (last_step),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .osc_count (osc_count),
        .trig      (trig),
        .gate      (gate),
        .step      (step),
        .playing   (playing)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 'h%0h expected 'h%0h", name, act, exp);
        end
    endtask

    // Reference model: expected outputs after each edge.
    logic [11:0] e_osc;
    logic        e_trig, e_gate, e_playing, m_rest;
    logic [2:0]  e_step;
    logic [15:0] m_tick;
    logic [12:0] pat [8];

    always @(posedge clk) begin
        int nxt;
        nxt = -1;
        if (!rst_n) begin
            e_osc = 0; e_trig = 0; e_gate = 0; e_playing = 0; e_step = 0;
            m_tick = 0; m_rest = 1;
            foreach (pat[i]) pat[i] = 13'h1000;
        end else begin
            e_trig = 0;
            e_gate = 0;
            if (run && (e_playing || !mute)) begin
                if (!e_playing) begin
                    e_playing = 1; m_tick = 0; e_step = 0; nxt = 0;
                end else if (mute) begin
                    // frozen: nothing advances, trig/gate silent
                end else if (m_tick == tempo_div) begin
                    m_tick = 0;
                    e_step = (e_step >= last_step) ? 3'd0 : e_step + 3'd1;
                    nxt = int'(e_step);
                end else begin
                    m_tick = m_tick + 16'd1;
                    e_gate = !m_rest && (m_tick < gate_len);
                end
            end else begin
                e_playing = 0; m_tick = 0; e_step = 0;
            end
            if (nxt >= 0) begin
                m_rest = pat[nxt][12];
                if (!m_rest) e_osc = pat[nxt][11:0];
                e_trig = !m_rest && (gate_len != 0);
                e_gate = e_trig;
            end
            if (wr_en) pat[wr_addr] = wr_data;
        end
    end

    always @(negedge clk) begin
        if (chk_en)
            check("cycle{osc,trig,gate,step,playing}",
                  {osc_count, trig, gate, step, playing},
                  {e_osc, e_trig, e_gate, e_step, e_playing});
    end

    task automatic wr(input int a, input int d);
        wr_en   = 1'b1;
        wr_addr = a[2:0];
        wr_data = d[12:0];
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic wait_step(input int s, input int budget);
        for (int i = 0; i < budget && step !== s[2:0]; i++) @(negedge clk);
        check("wait_step", step, s);
    endtask

    task automatic wait_trig(input int budget);
        for (int i = 0; i < budget && trig !== 1'b1; i++) @(negedge clk);
        check("wait_trig", trig, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, t;
        rst_n = 0; run = 0; mute = 0; wr_en = 0; wr_addr = 0; wr_data = 0;
        tempo_div = 16'd9; gate_len = 16'd4; last_step = 3'd3;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("rst_osc", osc_count, 0);
        check("rst_trig", trig, 0);
        check("rst_gate", gate, 0);
        check("rst_step", step, 0);
        check("rst_playing", playing, 0);
        rst_n = 1;

        // Four-step pattern, 10 cycles per step, gate high for 4.
        wr(0, 100); wr(1, 200); wr(2, 300); wr(3, 400);
        run = 1;
        for (int b = 0; b < 4; b++) begin
            int g, tc;
            g = 0; tc = 0;
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                if (c == 0) begin
                    check("s1_trig", trig, 1);
                    check("s1_osc", osc_count, exp_osc[b]);
                end
                g += int'(gate);
                tc += int'(trig);
            end
            check("s1_gate_cycles", g, 4);
            check("s1_trig_count", tc, 1);
        end

        // Rest step keeps previous period and stays silent.
        wr(1, 'h1000);
        wait_step(1, 40);
        check("rest_trig", trig, 0);
        check("rest_gate", gate, 0);
        check("rest_osc", osc_count, 100);

        // Mute for 7 cycles at tick 3 of step 2.
        wait_trig(40);
        check("s3_osc", osc_count, 300);
        repeat (3) @(negedge clk);
        mute = 1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            check("hold_frozen", {gate, trig, step}, {1'b0, 1'b0, 3'd2});
            if (i == 6) mute = 0;
        end
        @(negedge clk);
        check("resume_no_trig", trig, 0);
        check("resume_playing", playing, 1);
        k = 0;
        while (trig !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("resume_trig_delay", k, 6);
        check("resume_step", step, 3);
        check("resume_osc", osc_count, 400);

        // One-cycle steps alternating between two slots.
        run = 0;
        wr(1, 200);
        tempo_div = 16'd0; last_step = 3'd1; run = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("fast_trig", trig, 1);
            check("fast_osc", osc_count, (i % 2 == 1) ? 200 : 100);
        end

        // Lowering last_step below the current step wraps to 0.
        run = 0;
        wr(4, 500); wr(5, 600); wr(6, 700); wr(7, 800);
        tempo_div = 16'd3; last_step = 3'd7; gate_len = 16'd2; run = 1;
        wait_step(5, 60);
        check("ls_osc5", osc_count, 600);
        last_step = 3'd2;
        repeat (4) @(negedge clk);
        check("ls_wrap_step", step, 0);
        check("ls_wrap_osc", osc_count, 100);
        check("ls_wrap_trig", trig, 1);

        // Reset mid-step with gate high dominates write, run and mute.
        tempo_div = 16'd9; gate_len = 16'd4; last_step = 3'd3;
        @(negedge clk);
        check("pre_rst_gate", gate, 1);
        rst_n = 0; wr_en = 1; wr_addr = 3'd0; wr_data = 13'h0037; mute = 1;
        @(negedge clk);
        check("mid_rst_outs", {osc_count, trig, gate, step, playing}, 18'd0);
        rst_n = 1; wr_en = 0; mute = 0;
        t = 0;
        repeat (25) begin
            @(negedge clk);
            t += int'(trig);
        end
        check("post_rst_trigs", t, 0);
        check("post_rst_playing", playing, 1);
        check("post_rst_osc", osc_count, 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            rst_n = ($urandom_range(0, 299) != 0);
            if (i % 250 == 0) begin
                run       = 0;
                tempo_div = 16'($urandom_range(0, 6));
                gate_len  = 16'($urandom_range(0, 8));
            end else begin
                run = ($urandom_range(0, 29) != 0);
            end
            mute = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 19) == 0) last_step = 3'($urandom_range(0, 7));
            wr_en   = ($urandom_range(0, 3) == 0);
            wr_addr = 3'($urandom_range(0, 7));
            wr_data = {($urandom_range(0, 3) == 0), 12'($urandom_range(0, 4095))};
        end
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/note_seq.md
NOTE_SEQ -- requirements
Module: note_seq

Interface
REQ-001 SHALL have parameter STEPS, default 8: number of pattern slots (power of two; index width SW = log2(STEPS) = 3).
REQ-002 SHALL have parameter TW, default 16: width of tempo and gate counters.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port run  input  1  level; 1 = play pattern, 0 = stop.
REQ-006 SHALL have port mute  input  1  level; 1 = freeze playback (asserted while synth is being programmed over SPI).
REQ-007 SHALL have port tempo_div  input  TW  step length minus one, in clk cycles.
REQ-008 SHALL have port gate_len  input  TW  gate-high cycles per step.
REQ-009 SHALL have port last_step  input  SW  index of final step before wrap to 0.
REQ-010 SHALL have port wr_en  input  1  pattern write strobe.
REQ-011 SHALL have port wr_addr  input  SW  pattern slot to write.
REQ-012 SHALL have port wr_data  input  13  {rest, count[11:0]}; rest=1 means silent step.
REQ-013 SHALL have port osc_count  output  12  oscillator period for the oscillator.
REQ-014 SHALL have port trig  output  1  one-cycle note-on pulse for the ADSR.
REQ-015 SHALL have port gate  output  1  note-held level for the ADSR.
REQ-016 SHALL have port step  output  SW  index of current step.
REQ-017 SHALL have port playing  output  1  high in PLAY and HOLD states.

Function
REQ-018 SHALL implement states IDLE, PLAY, HOLD; all outputs registered.
REQ-019 SHALL write wr_data into slot wr_addr on any cycle with wr_en=1, in every state.
REQ-020 SHALL, in IDLE with run=1 and mute=0, enter PLAY with step=0 and tick=0 on the next edge.
REQ-021 SHALL define step start as the edge on which tick becomes 0 in PLAY (entry from IDLE or wrap).
REQ-022 SHALL, at step start, latch osc_count from the slot's count if rest=0; hold previous osc_count if rest=1.
REQ-023 SHALL assert trig for exactly the first PLAY cycle of a step when rest=0 and gate_len!=0; otherwise trig=0.
REQ-024 SHALL drive gate=1 during a step while tick < gate_len and rest=0; gate=0 otherwise.
REQ-025 SHALL increment tick each PLAY cycle; when tick == tempo_div, set tick=0 and advance step (step length = tempo_div+1 cycles).
REQ-026 SHALL advance step to 0 when step >= last_step, else step+1 (last_step lowered below step wraps immediately).
REQ-027 SHALL, for gate_len > tempo_div, keep gate high for the whole step, with trig still pulsing at each non-rest step start.
REQ-028 SHALL, with tempo_div=0, start a new step every cycle; trig high each cycle whose slot is non-rest.
REQ-029 SHALL use the pre-write slot contents when wr_en targets the slot being latched on the same edge.
REQ-030 SHALL, in PLAY with mute=1, enter HOLD: tick and step frozen, gate=0, trig=0, osc_count held.
REQ-031 SHALL, in HOLD with mute=0, return to PLAY continuing from frozen tick without re-triggering; gate re-evaluated per REQ-024.
REQ-032 SHALL, in PLAY or HOLD with run=0, go to IDLE next edge: step=0, tick=0, gate=0, trig=0, osc_count held; run=0 takes priority over mute.

Reset
REQ-033 SHALL, on rising edge with rst_n=0, set state=IDLE, tick=0, step=0, osc_count=0, trig=0, gate=0, playing=0, all slots=13'h1000 (rest).
REQ-034 SHALL treat reset as dominant over wr_en, run and mute, including mid-step.

Verification
REQ-035 SHALL cover: slots 0..3 = 100,200,300,400, last_step=3, tempo_div=9, gate_len=4, run=1 -> trig every 10 cycles, osc_count 100,200,300,400,100..., gate high 4 of 10 cycles.
REQ-036 SHALL cover: slot 1 rest=1, slot 0 count=100 -> at step 1 trig=0, gate=0, osc_count stays 100.
REQ-037 SHALL cover: mute=1 for 7 cycles at tick=3 -> gate=0, tick/step frozen; after release next trig occurs exactly tempo_div-3 cycles later, none on resume.
REQ-038 SHALL cover: tempo_div=0, last_step=1, both slots non-rest -> trig constant high, osc_count alternates each cycle.
REQ-039 SHALL cover: rst_n=0 mid-step with gate=1 -> next edge all outputs 0, step=0, all slots rest; run=1 afterwards yields trig=0.
REQ-040 SHALL cover: last_step changed 7->2 while step=5 -> next step is 0.
